// File: rtl/sampstream_framer_if.sv
// Sample-stream pull handshake plus the valid/ready byte stream toward the host.
// master = framer side, slave = upstream queue / host transmit side.
interface sampstream_framer_if;
    logic [31:0] samp_stream_data;
    logic [7:0]  samp_stream_count;
    logic        samp_stream_avail;
    logic        samp_stream_pull;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  samp_stream_data, samp_stream_count, samp_stream_avail, tx_ready,
        output samp_stream_pull, tx_data, tx_valid
    );

    modport slave (
        output samp_stream_data, samp_stream_count, samp_stream_avail, tx_ready,
        input  samp_stream_pull, tx_data, tx_valid
    );
endinterface

// File: rtl/sampstream_framer.sv
// Wraps sample bursts into A5/seq/n/payload/checksum byte packets; 1st byte the cycle after start, 5+5n cycles per packet.
// tx_ready low holds tx_data/tx_valid stable; samples are pulled only as payload space is reached.
module sampstream_framer #(
    parameter int MAX_BURST = 64,
    parameter int SETTLE    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    sampstream_framer_if.master        stream,
    output logic                       busy,
    output logic [31:0]                sample_total
);
    localparam logic [7:0] MAX_B    = 8'(MAX_BURST);
    localparam logic [3:0] SETTLE_W = 4'(SETTLE);

    typedef enum logic [2:0] {IDLE, HDR, LOAD, DATA, CSUM} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx;
    logic [7:0]  n;
    logic [7:0]  remaining;
    logic [7:0]  seq;
    logic [7:0]  sum;
    logic [31:0] shreg;
    logic [3:0]  settle;
    logic        pull_q;
    logic        xfer;
    logic        start;
    logic        load_go;

    assign xfer    = stream.tx_valid && stream.tx_ready;
    assign start   = (state == IDLE) && enable && stream.samp_stream_avail &&
                     (stream.samp_stream_count != 8'd0) && (settle == 4'd0);
    assign load_go = (state == LOAD) && (settle == 4'd0) && stream.samp_stream_avail;

    assign busy                    = (state != IDLE);
    assign stream.samp_stream_pull = pull_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        stream.tx_valid = 1'b0;
        stream.tx_data  = 8'h00;
        case (state)
            IDLE: if (start) state_nxt = HDR;
            HDR: begin
                stream.tx_valid = 1'b1;
                case (idx)
                    2'd0:    stream.tx_data = 8'hA5;
                    2'd1:    stream.tx_data = seq;
                    default: stream.tx_data = n;
                endcase
                if (xfer && idx == 2'd2) state_nxt = LOAD;
            end
            LOAD: if (load_go) state_nxt = DATA;
            DATA: begin
                stream.tx_valid = 1'b1;
                stream.tx_data  = shreg[7:0];
                if (xfer && idx == 2'd3)
                    state_nxt = (remaining == 8'd1) ? CSUM : LOAD;
            end
            CSUM: begin
                stream.tx_valid = 1'b1;
                stream.tx_data  = sum;
                if (xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= 2'd0;
            n            <= 8'd0;
            remaining    <= 8'd0;
            seq          <= 8'd0;
            sum          <= 8'd0;
            shreg        <= 32'd0;
            settle       <= 4'd0;
            pull_q       <= 1'b0;
            sample_total <= 32'd0;
        end else begin
            pull_q <= load_go;
            // settle restarts on the pull edge so avail/data/count are ignored while upstream updates
            if (load_go)             settle <= SETTLE_W;
            else if (settle != 4'd0) settle <= settle - 4'd1;

            if (start) begin
                n         <= (stream.samp_stream_count > MAX_B) ? MAX_B : stream.samp_stream_count;
                remaining <= (stream.samp_stream_count > MAX_B) ? MAX_B : stream.samp_stream_count;
                sum       <= 8'd0;
                idx       <= 2'd0;
            end

            if (xfer) begin
                if (!(state == HDR && idx == 2'd0))
                    sum <= sum + stream.tx_data;
                idx <= (state == HDR && idx == 2'd2) ? 2'd0 : idx + 2'd1;
                if (state == DATA) begin
                    shreg <= {8'h00, shreg[31:8]};
                    if (idx == 2'd3) remaining <= remaining - 8'd1;
                end
                if (state == CSUM) seq <= seq + 8'd1;
            end

            if (load_go) begin
                shreg        <= stream.samp_stream_data;
                sample_total <= sample_total + 32'd1;
                idx          <= 2'd0;
            end
        end
    end
endmodule

// File: tb/tb_sampstream_framer.sv
// Randomized bench: upstream queue model and packet reference model feed a byte scoreboard.
// A separate monitor pops expected bytes on every accepted transfer and checks hold/pull spacing.
module tb_sampstream_framer;
    localparam int MAX_BURST = 64;
    localparam int SETTLE    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [31:0] sample_total;

    sampstream_framer_if ifc();

    sampstream_framer #(.MAX_BURST(MAX_BURST), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .stream       (ifc),
        .busy         (busy),
        .sample_total (sample_total)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] fifo[$];
    logic [31:0] pend[$];
    logic [7:0]  cnt_lag = 8'd0;
    int          gap = 0;
    bit          gap_arm = 0;
    int          ready_pct = 100;

    logic [7:0]  m_seq = 8'd0;
    logic [31:0] m_total = 32'd0;
    int          m_pulls = 0;

    int          acc_cnt = 0;
    int          pull_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    // One cycle of stimulus at the falling edge: upstream queue, lagging count, gaps, random ready.
    task automatic tick();
        @(negedge clk);
        if (ifc.samp_stream_pull && fifo.size() > 0) begin
            fifo.delete(0);
            if (gap_arm) begin
                gap     = 10;
                gap_arm = 0;
            end
        end else if (gap > 0) begin
            gap--;
        end
        ifc.samp_stream_count = cnt_lag;
        cnt_lag               = 8'((fifo.size() > 255) ? 255 : fifo.size());
        ifc.samp_stream_avail = (fifo.size() > 0) && (gap == 0);
        ifc.samp_stream_data  = (fifo.size() > 0) ? fifo[0] : 32'h0;
        ifc.tx_ready          = ($urandom_range(99) < ready_pct);
    endtask

    // Reference model: the queued burst becomes packets of at most MAX_BURST samples each.
    task automatic commit();
        int         left;
        int         pos;
        int         nn;
        logic [7:0] s;
        logic [7:0] b;
        left = pend.size();
        pos  = 0;
        while (left > 0) begin
            nn = (left > MAX_BURST) ? MAX_BURST : left;
            exp_q.push_back(8'hA5);
            exp_q.push_back(m_seq);
            exp_q.push_back(8'(nn));
            s = m_seq + 8'(nn);
            for (int i = 0; i < nn; i++) begin
                for (int k = 0; k < 4; k++) begin
                    b = pend[pos + i][8*k +: 8];
                    exp_q.push_back(b);
                    s = s + b;
                end
            end
            exp_q.push_back(s);
            m_seq   = m_seq + 8'd1;
            m_total = m_total + 32'(nn);
            m_pulls = m_pulls + nn;
            pos     = pos + nn;
            left    = left - nn;
        end
        foreach (pend[i]) fifo.push_back(pend[i]);
        pend.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget, output int bcyc);
        int  n;
        bit  done;
        n    = 0;
        bcyc = 0;
        done = (exp_q.size() == 0) && !busy && (fifo.size() == 0);
        while (!done && n < budget) begin
            tick();
            n++;
            if (busy) bcyc++;
            done = (exp_q.size() == 0) && !busy && (fifo.size() == 0);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout act=pending_bytes_%0d req=idle", tag, exp_q.size());
        end
        chk({tag, "_sample_total"}, sample_total, m_total);
        chk({tag, "_pulls"}, 32'(pull_cnt), 32'(m_pulls));
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Monitor: sampled 1 time unit before each rising edge.
    initial begin : monitor
        int         mcyc;
        int         last_pull;
        bit         prev_stall;
        logic [7:0] prev_data;
        mcyc       = 0;
        last_pull  = -100;
        prev_stall = 0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            #4;
            mcyc++;
            if (rst) begin
                prev_stall = 0;
                last_pull  = -100;
            end else begin
                if (prev_stall) begin
                    chk("tx_hold_valid", {31'd0, ifc.tx_valid}, 32'd1);
                    chk("tx_hold_data", {24'd0, ifc.tx_data}, {24'd0, prev_data});
                end
                if (ifc.tx_valid && ifc.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte act=%h req=none", ifc.tx_data);
                    end else begin
                        chk("tx_byte", {24'd0, ifc.tx_data}, {24'd0, exp_q.pop_front()});
                    end
                    acc_cnt++;
                end
                if (ifc.samp_stream_pull) begin
                    chk("pull_spacing_ok", {31'd0, (mcyc - last_pull) >= SETTLE + 1}, 32'd1);
                    last_pull = mcyc;
                    pull_cnt++;
                end
                prev_stall = ifc.tx_valid && !ifc.tx_ready;
                prev_data  = ifc.tx_data;
            end
        end
    end

    initial begin : stim
        int bcyc;
        int base;
        int n;
        rst                   = 1'b1;
        enable                = 1'b0;
        ifc.samp_stream_data  = 32'h0;
        ifc.samp_stream_count = 8'd0;
        ifc.samp_stream_avail = 1'b0;
        ifc.tx_ready          = 1'b0;

        tick();
        tick();
        chk("rst_tx_valid", {31'd0, ifc.tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, ifc.tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pull", {31'd0, ifc.samp_stream_pull}, 32'd0);
        chk("rst_sample_total", sample_total, 32'd0);
        rst    = 1'b0;
        enable = 1'b1;
        tick();

        // Basic packet with fixed samples; busy spans 3 header + 2*(1+4) + 1 checksum cycles.
        pend.push_back(32'h11223344);
        pend.push_back(32'h55667788);
        commit();
        wait_idle("basic", 200, bcyc);
        chk("basic_busy_cycles", 32'(bcyc), 32'd14);

        // Burst cap: 200 samples become 64/64/64/8.
        for (int i = 0; i < 200; i++) pend.push_back($urandom());
        commit();
        wait_idle("burst_cap", 3000, bcyc);

        // Backpressure at 30% ready.
        ready_pct = 30;
        for (int i = 0; i < 24; i++) pend.push_back($urandom());
        commit();
        wait_idle("backpressure", 3000, bcyc);
        ready_pct = 100;

        // Upstream avail gap of 10 cycles after the first pull.
        gap_arm = 1;
        for (int i = 0; i < 4; i++) pend.push_back($urandom());
        commit();
        wait_idle("avail_gap", 500, bcyc);

        // Reset while the 3rd payload byte is presented.
        pend.push_back($urandom());
        pend.push_back($urandom());
        commit();
        base = acc_cnt;
        n    = 0;
        while (!((acc_cnt - base) == 5 && ifc.tx_valid) && n < 200) begin
            tick();
            n++;
        end
        chk("mid_reset_reached", {31'd0, n < 200}, 32'd1);
        rst          = 1'b1;
        enable       = 1'b0;
        ifc.tx_ready = 1'b0;
        exp_q.delete();
        tick();
        chk("mid_reset_tx_valid", {31'd0, ifc.tx_valid}, 32'd0);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_pull", {31'd0, ifc.samp_stream_pull}, 32'd0);
        chk("mid_reset_sample_total", sample_total, 32'd0);
        rst = 1'b0;
        fifo.delete();
        m_seq    = 8'd0;
        m_total  = 32'd0;
        m_pulls  = 0;
        pull_cnt = 0;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) pend.push_back($urandom());
        commit();
        wait_idle("after_reset", 500, bcyc);

        // enable low: samples present but nothing may start.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) fifo.push_back($urandom());
        for (int i = 0; i < 40; i++) tick();
        chk("disabled_busy", {31'd0, busy}, 32'd0);
        chk("disabled_pulls", 32'(pull_cnt), 32'(m_pulls));
        chk("disabled_sample_total", sample_total, m_total);
        fifo.delete();
        tick();
        tick();
        enable = 1'b1;

        // 257 single-sample packets: seq passes FF and wraps to 00.
        for (int p = 0; p < 257; p++) begin
            pend.push_back($urandom());
            commit();
            wait_idle("seq_wrap", 200, bcyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
